// File: rtl/sync_fifo_p.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_fifo_p : single-clock FIFO, registered read data and flags    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sync_fifo_p #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          data_op,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);
  localparam logic [CW-1:0] c_af    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] c_ae    = CW'(AE_LEVEL);

  if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 4 || DEPTH > 1024) begin : g_bad_depth
    $fatal(1, "sync_fifo_p: DEPTH must be a power of 2 in 4..1024");
  end
  if (!(AE_LEVEL > 0 && AE_LEVEL < AF_LEVEL && AF_LEVEL < DEPTH)) begin : g_bad_levels
    $fatal(1, "sync_fifo_p: require 0 < AE_LEVEL < AF_LEVEL < DEPTH");
  end
  if (DATA_W < 1 || DATA_W > 256) begin : g_bad_width
    $fatal(1, "sync_fifo_p: DATA_W must be in 1..256");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] data_op_q, data_op_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              af_q, af_d;
  logic              ae_q, ae_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              rd_accept;
  logic              wr_accept;

  // A read frees a slot in the same cycle, so a full FIFO may still accept a write.
  always_comb begin
    rd_accept = rd_en && !empty_q;
    wr_accept = wr_en && (!full_q || rd_accept);

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    data_op_d = data_op_q;

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (rd_accept) begin
      rd_ptr_d  = rd_ptr_q + PW'(1);
      data_op_d = mem_q[rd_ptr_q];
    end

    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Flags derive from the next count so they are valid right after the edge.
    full_d  = (count_d == c_depth);
    empty_d = (count_d == '0);
    af_d    = (count_d >= c_af);
    ae_d    = (count_d <= c_ae);
    ovf_d   = wr_en && !wr_accept;
    unf_d   = rd_en && !rd_accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      data_op_q <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      data_op_q <= data_op_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      af_q      <= af_d;
      ae_q      <= ae_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  // Storage is not reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_op      = data_op_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_p.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sync_fifo_p : directed vectors plus random run vs queue model   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_sync_fifo_p;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int AF     = 3;
  localparam int AE     = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_en = 1'b0;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [DATA_W-1:0] data_op;
  logic              full, empty, almost_full, almost_empty, overflow, underflow;
  logic [2:0]        count;

  int n_checks = 0;
  int n_fail   = 0;

  sync_fifo_p #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_op(data_op), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, wr, rd;
    logic [31:0] din;
    int          cnt;
    logic        f, e, af, ae, ov, un;
    logic [31:0] dop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic w, logic rd, logic [31:0] d, int c,
                              logic f, logic e, logic af, logic ae,
                              logic ov, logic un, logic [31:0] dop);
    vec_t v;
    v.rst = r; v.wr = w; v.rd = rd; v.din = d; v.cnt = c;
    v.f = f; v.e = e; v.af = af; v.ae = ae; v.ov = ov; v.un = un; v.dop = dop;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step(logic r, logic w, logic rd, logic [31:0] d);
    rst = r; wr_en = w; rd_en = rd; data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(int idx, int c, logic f, logic e, logic af, logic ae,
                         logic ov, logic un, logic [31:0] dop);
    chk("count", idx, 32'(count), 32'(c));
    chk("full", idx, 32'(full), 32'(f));
    chk("empty", idx, 32'(empty), 32'(e));
    chk("almost_full", idx, 32'(almost_full), 32'(af));
    chk("almost_empty", idx, 32'(almost_empty), 32'(ae));
    chk("overflow", idx, 32'(overflow), 32'(ov));
    chk("underflow", idx, 32'(underflow), 32'(un));
    chk("data_op", idx, data_op, dop);
  endtask

  // Reference model: a bounded queue with the accept rules stated in words.
  logic [31:0] mq[$];
  logic [31:0] m_dout;

  initial begin
    logic [31:0] a [4];
    logic [31:0] b0, d0, c0;
    logic [31:0] w [10];
    for (int i = 0; i < 4; i++) a[i] = 32'hA000_0000 + 32'(i);
    b0 = 32'hB000_0000; d0 = 32'hD000_0000; c0 = 32'hC000_0000;

    // rst wr rd din        cnt f e af ae ov un dop
    vecs.push_back(mk(1,0,0,32'h0,   0,0,1,0,1,0,0,32'h0));
    vecs.push_back(mk(0,1,0,a[0],    1,0,0,0,1,0,0,32'h0));
    vecs.push_back(mk(0,1,0,a[1],    2,0,0,0,0,0,0,32'h0));
    vecs.push_back(mk(0,1,0,a[2],    3,0,0,1,0,0,0,32'h0));
    vecs.push_back(mk(0,1,0,a[3],    4,1,0,1,0,0,0,32'h0));
    vecs.push_back(mk(0,1,0,32'hFF,  4,1,0,1,0,1,0,32'h0));
    vecs.push_back(mk(0,0,0,32'h0,   4,1,0,1,0,0,0,32'h0));
    vecs.push_back(mk(0,0,1,32'h0,   3,0,0,1,0,0,0,a[0]));
    vecs.push_back(mk(0,0,1,32'h0,   2,0,0,0,0,0,0,a[1]));
    vecs.push_back(mk(0,0,1,32'h0,   1,0,0,0,1,0,0,a[2]));
    vecs.push_back(mk(0,0,1,32'h0,   0,0,1,0,1,0,0,a[3]));
    vecs.push_back(mk(0,0,1,32'h0,   0,0,1,0,1,0,1,a[3]));
    vecs.push_back(mk(0,1,1,d0,      1,0,0,0,1,0,1,a[3]));
    vecs.push_back(mk(0,0,1,32'h0,   0,0,1,0,1,0,0,d0));
    vecs.push_back(mk(0,1,0,a[0],    1,0,0,0,1,0,0,d0));
    vecs.push_back(mk(0,1,0,a[1],    2,0,0,0,0,0,0,d0));
    vecs.push_back(mk(0,1,0,a[2],    3,0,0,1,0,0,0,d0));
    vecs.push_back(mk(0,1,0,a[3],    4,1,0,1,0,0,0,d0));
    vecs.push_back(mk(0,1,1,b0,      4,1,0,1,0,0,0,a[0]));
    vecs.push_back(mk(0,0,1,32'h0,   3,0,0,1,0,0,0,a[1]));
    vecs.push_back(mk(0,0,1,32'h0,   2,0,0,0,0,0,0,a[2]));
    vecs.push_back(mk(0,0,1,32'h0,   1,0,0,0,1,0,0,a[3]));
    vecs.push_back(mk(0,0,1,32'h0,   0,0,1,0,1,0,0,b0));
    vecs.push_back(mk(0,1,0,32'hC1,  1,0,0,0,1,0,0,b0));
    vecs.push_back(mk(0,1,0,32'hC2,  2,0,0,0,0,0,0,b0));
    vecs.push_back(mk(0,1,0,32'hC3,  3,0,0,1,0,0,0,b0));
    vecs.push_back(mk(1,1,1,32'hC4,  0,0,1,0,1,0,0,32'h0));
    vecs.push_back(mk(0,1,0,c0,      1,0,0,0,1,0,0,32'h0));
    vecs.push_back(mk(0,0,1,32'h0,   0,0,1,0,1,0,0,c0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].din);
      chk_all(i, vecs[i].cnt, vecs[i].f, vecs[i].e, vecs[i].af, vecs[i].ae,
              vecs[i].ov, vecs[i].un, vecs[i].dop);
    end

    // Ten words streamed through a depth-4 FIFO at occupancy 2: pointers wrap twice.
    for (int i = 0; i < 10; i++) w[i] = 32'h5000_0000 + 32'(i * 7);
    step(0, 1, 0, w[0]); chk("wrap_count", 100, 32'(count), 32'd1);
    step(0, 1, 0, w[1]); chk("wrap_count", 101, 32'(count), 32'd2);
    for (int i = 2; i < 10; i++) begin
      step(0, 1, 1, w[i]);
      chk("wrap_data", 100 + i, data_op, w[i-2]);
      chk("wrap_count", 100 + i, 32'(count), 32'd2);
      chk("wrap_ae", 100 + i, 32'(almost_empty), 32'd0);
    end
    step(0, 0, 1, 32'h0);
    chk("wrap_data", 110, data_op, w[8]);
    chk("wrap_ae", 110, 32'(almost_empty), 32'd1);
    step(0, 0, 1, 32'h0);
    chk("wrap_data", 111, data_op, w[9]);
    chk("wrap_empty", 111, 32'(empty), 32'd1);

    // Randomised run against the queue model.
    step(1, 0, 0, 32'h0);
    mq.delete();
    m_dout = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic r, wv, rv, rd_ok, wr_ok, m_ov, m_un;
      logic [31:0] d;
      int sz;
      r  = ($urandom_range(0, 99) == 0);
      wv = ($urandom_range(0, 99) < ((cyc / 300) % 2 == 0 ? 70 : 35));
      rv = ($urandom_range(0, 99) < ((cyc / 300) % 2 == 0 ? 35 : 70));
      d  = $urandom;
      step(r, wv, rv, d);
      m_ov = 1'b0; m_un = 1'b0;
      if (r) begin
        mq.delete();
        m_dout = '0;
      end else begin
        rd_ok = rv && (mq.size() > 0);
        wr_ok = wv && (mq.size() < DEPTH || rd_ok);
        if (rd_ok) m_dout = mq.pop_front();
        if (wr_ok) mq.push_back(d);
        m_ov = wv && !wr_ok;
        m_un = rv && !rd_ok;
      end
      sz = mq.size();
      chk_all(1000 + cyc, sz, sz == DEPTH, sz == 0, sz >= AF, sz <= AE,
              m_ov, m_un, m_dout);
    end

    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_fifo_p.md
SYNC_FIFO_P -- requirements
Module: sync_fifo_p

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning data word width in bits (1..256).
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning number of storage words (power of 2, 4..1024).
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, meaning almost_full asserts when count >= AF_LEVEL.
REQ-004 The block SHALL have parameter AE_LEVEL, default 2, meaning almost_empty asserts when count <= AE_LEVEL.
REQ-005 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-007 The block SHALL have port wr_en, input, 1, meaning write request.
REQ-008 The block SHALL have port data_in, input, DATA_W, meaning write data.
REQ-009 The block SHALL have port rd_en, input, 1, meaning read request.
REQ-010 The block SHALL have port data_op, output, DATA_W, meaning registered read data.
REQ-011 The block SHALL have port full, output, 1, meaning count == DEPTH.
REQ-012 The block SHALL have port empty, output, 1, meaning count == 0.
REQ-013 The block SHALL have ports almost_full and almost_empty, output, 1 each, meaning the threshold flags of REQ-003/REQ-004.
REQ-014 The block SHALL have port count, output, $clog2(DEPTH)+1, meaning number of words stored.
REQ-015 The block SHALL have ports overflow and underflow, output, 1 each, meaning one-cycle error pulses.

Function
REQ-016 Write accept SHALL be wr_en && (!full || rd_accept); data_in is stored at wr_ptr and wr_ptr increments modulo DEPTH.
REQ-017 Read accept (rd_accept) SHALL be rd_en && !empty; no bypass: a read in the same cycle as a write into an empty FIFO is rejected.
REQ-018 On read accept, data_op SHALL take mem[rd_ptr] at the same clock edge (1-cycle latency), and rd_ptr increments modulo DEPTH.
REQ-019 data_op SHALL hold its last value on cycles with no read accept.
REQ-020 count SHALL be +1 on write-only accept, -1 on read-only accept, and unchanged on both or neither.
REQ-021 Simultaneous read and write at full SHALL both be accepted; count stays DEPTH, full stays 1, and the read returns the oldest word.
REQ-022 full, empty, almost_full and almost_empty SHALL be registered and reflect the count after the same edge, with no lag cycle.
REQ-023 overflow SHALL pulse 1 for one cycle after an edge where wr_en=1 was rejected; storage and pointers are unchanged.
REQ-024 underflow SHALL pulse 1 for one cycle after an edge where rd_en=1 was rejected; data_op is unchanged.
REQ-025 Pointers SHALL wrap from DEPTH-1 to 0 with no data loss or reordering; data order is strictly first in, first out.
REQ-026 Parameter legality (DEPTH power of 2, 0 < AE_LEVEL < AF_LEVEL < DEPTH) SHALL be checked at elaboration, with a fatal error on violation.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL set wr_ptr=0, rd_ptr=0, count=0, data_op=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
REQ-028 rst SHALL take priority over wr_en and rd_en in the same cycle; memory contents need not be cleared.
REQ-029 A reset during operation SHALL discard all stored words; the first read after reset returns the first word written after reset.

Verification (DEPTH=4, AF_LEVEL=3, AE_LEVEL=1, DATA_W=32)
REQ-030 Reset, then write A0..A3 -> count 1,2,3,4; almost_full at count 3; full=1 after the 4th write; empty=0 after the 1st write.
REQ-031 From full, wr_en=1 only -> overflow pulses one cycle, count=4; then 4 reads -> data_op A0,A1,A2,A3 each one cycle after rd_en; empty=1 after the last read.
REQ-032 From empty, rd_en=1 -> underflow pulses, data_op keeps its last value; write+read in the same cycle on empty -> write accepted, read rejected, underflow=1, count=1.
REQ-033 From full, wr_en=rd_en=1 with data B0 -> data_op=A0, count=4, full=1, no overflow; after draining, the last word is B0.
REQ-034 Write and read for 10 words across pointer wrap (count kept at 1..3) -> output sequence matches input exactly; almost_empty tracks count<=1.
REQ-035 Reset asserted at count=3 -> next cycle count=0, empty=1, data_op=0; a following write C0 then read -> data_op=C0.
